// File: rtl/cla_serial_add_seq.sv
// rtl/cla_serial_add_seq.sv - multi-cycle wide adder reusing one 4-bit carry-lookahead slice per nibble
//
// Adds op1 + op2 + cin over NSLICE = WIDTH/4 clock beats, least-significant nibble first.
// One 4-bit carry-lookahead slice is shared by every beat. The carry between beats is held in a register.
// Valid/ready handshakes are used on both the operand side and the result side.
//
// Optional feature: define CLA_SEQ_SUB_EN to add the 'sub' input, which selects A - B.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   operands and cin are valid
//   in_ready   block accepts an operation this cycle (combinational)
//   op1, op2   addends, WIDTH bits
//   cin        carry in
//   sub        (CLA_SEQ_SUB_EN only) 1 = compute op1 - op2, sampled at accept
//   res_valid  sum/cout/ovf valid (registered)
//   res_ready  consumer takes the result
//   sum        A+B+cin mod 2^WIDTH
//   cout       carry out of bit WIDTH-1
//   ovf        signed overflow

module cla_serial_add_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / 4;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             res_valid_q;

    // Operand B and carry-in as loaded at accept; subtraction is A + ~B + 1.
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    always_comb begin
        b_load = op2;
        c_load = cin;
`ifdef CLA_SEQ_SUB_EN
        if (sub) begin
            b_load = ~op2;
            c_load = 1'b1;
        end
`endif
    end

    // 4-bit carry-lookahead slice on the low nibble of the shifting operand registers.
    logic [3:0] sl_a, sl_b, sl_p, sl_g, sl_s;
    logic [4:0] sl_c;

    always_comb begin
        sl_a    = a_q[3:0];
        sl_b    = b_q[3:0];
        sl_p    = sl_a ^ sl_b;
        sl_g    = sl_a & sl_b;
        sl_c[0] = carry_q;
        sl_c[1] = sl_g[0] | (sl_p[0] & sl_c[0]);
        sl_c[2] = sl_g[1] | (sl_p[1] & sl_g[0]) | (sl_p[1] & sl_p[0] & sl_c[0]);
        sl_c[3] = sl_g[2] | (sl_p[2] & sl_g[1]) | (sl_p[2] & sl_p[1] & sl_g[0])
                | (sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
        sl_c[4] = sl_g[3] | (sl_p[3] & sl_g[2]) | (sl_p[3] & sl_p[2] & sl_g[1])
                | (sl_p[3] & sl_p[2] & sl_p[1] & sl_g[0])
                | (sl_p[3] & sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
        sl_s    = sl_p ^ sl_c[3:0];
    end

    // A waiting result is retired on the same edge that a new operation loads.
    assign in_ready = (state == IDLE) | ((state == DONE) & res_ready);

    logic accept;
    assign accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q     <= op1;
                        b_q     <= b_load;
                        carry_q <= c_load;
                        cnt     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 4;
                    b_q     <= b_q >> 4;
                    sum_q   <= {sl_s, sum_q[WIDTH-1:4]};
                    carry_q <= sl_c[4];
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cout_q      <= sl_c[4];
                        // The carry into bit 3 of the final slice is the carry into the MSB.
                        ovf_q       <= sl_c[3] ^ sl_c[4];
                        res_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        if (in_valid) begin
                            a_q     <= op1;
                            b_q     <= b_load;
                            carry_q <= c_load;
                            cnt     <= '0;
                            state   <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign res_valid = res_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_serial_add_seq.sv
// tb/tb_cla_serial_add_seq.sv - directed self-checking bench for cla_serial_add_seq

module tb_cla_serial_add_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        cin;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
`ifdef CLA_SEQ_SUB_EN
    logic        sub;
    logic        v8, rdy8, cin8, rv8, rr8, cout8, ovf8, sub8;
    logic [7:0]  a8, b8, s8;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cla_serial_add_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .cin       (cin),
`ifdef CLA_SEQ_SUB_EN
        .sub       (sub),
`endif
        .res_valid (res_valid),
        .res_ready (res_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

`ifdef CLA_SEQ_SUB_EN
    cla_serial_add_seq #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v8),
        .in_ready  (rdy8),
        .op1       (a8),
        .op2       (b8),
        .cin       (cin8),
        .sub       (sub8),
        .res_valid (rv8),
        .res_ready (rr8),
        .sum       (s8),
        .cout      (cout8),
        .ovf       (ovf8)
    );
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until res_valid is seen, bounded.
    task automatic wait_result(output int n);
        n = 0;
        while (!res_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    // Accept one op from IDLE, wait for its result, check it, retire it.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic [31:0] es, input logic ec, input logic eo);
        int n;
        op1 = a; op2 = b; cin = c; in_valid = 1'b1; res_ready = 1'b1;
        check({tag, "_rdy"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        wait_result(n);
        check({tag, "_lat"}, n, 8);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, cout, ec);
        check({tag, "_ovf"}, ovf, eo);
        tick();
        check({tag, "_retire"}, res_valid, 1'b0);
    endtask

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; op1 = '0; op2 = '0; cin = 1'b0; res_ready = 1'b0;
`ifdef CLA_SEQ_SUB_EN
        sub = 1'b0; v8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; rr8 = 1'b0; sub8 = 1'b0;
`endif
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_sum", sum, 32'h0);
        check("rst_cout", cout, 1'b0);
        check("rst_ovf", ovf, 1'b0);

        // Full carry ripple through all eight nibbles.
        run_op("t2", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_op("cin", 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
        run_op("mix", 32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_op("negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        run_op("plain", 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0);

        // Positive overflow, then held under backpressure.
        op1 = 32'h7FFF_FFFF; op2 = 32'h0000_0001; cin = 1'b0; in_valid = 1'b1; res_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_result(n);
        check("t3_lat", n, 8);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", res_valid, 1'b1);
            check("t3_hold_sum", sum, 32'h8000_0000);
            check("t3_hold_cout", cout, 1'b0);
            check("t3_hold_ovf", ovf, 1'b1);
            check("t3_hold_in_ready", in_ready, 1'b0);
            tick();
        end
        res_ready = 1'b1;
        #1;
        check("t3_ready_comb", in_ready, 1'b1);
        tick();
        check("t3_idle", res_valid, 1'b0);

        // Back-to-back with same-edge handoff.
        op1 = 32'd1; op2 = 32'd2; cin = 1'b0; in_valid = 1'b1; res_ready = 1'b1;
        tick();
        op1 = 32'd3; op2 = 32'd4;
        check("t4_run_in_ready", in_ready, 1'b0);
        wait_result(n);
        check("t4_lat1", n, 8);
        check("t4_sum1", sum, 32'h0000_0003);
        check("t4_handoff_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check("t4_no_bubble", res_valid, 1'b0);
        wait_result(n);
        check("t4_lat2", n, 8);
        check("t4_sum2", sum, 32'h0000_0007);
        tick();

        // Reset in the middle of a run drops the result.
        op1 = 32'd1; op2 = 32'd1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_no_valid", res_valid, 1'b0);
        check("t5_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t5_stays_idle", res_valid, 1'b0);
        end
        run_op("t5", 32'd5, 32'd5, 1'b0, 32'h0000_000A, 1'b0, 1'b0);

`ifdef CLA_SEQ_SUB_EN
        // 8-bit subtraction: 05-07 borrows, 80-01 overflows.
        for (int k = 0; k < 2; k++) begin
            logic [7:0] ea, eb, es;
            logic       ec, eo;
            if (k == 0) begin ea = 8'h05; eb = 8'h07; es = 8'hFE; ec = 1'b0; eo = 1'b0; end
            else        begin ea = 8'h80; eb = 8'h01; es = 8'h7F; ec = 1'b1; eo = 1'b1; end
            a8 = ea; b8 = eb; sub8 = 1'b1; cin8 = 1'b0; v8 = 1'b1; rr8 = 1'b1;
            tick();
            v8 = 1'b0;
            n = 0;
            while (!rv8 && n < 20) begin
                tick();
                n++;
            end
            check("t6_lat", n, 2);
            check("t6_sum", s8, es);
            check("t6_cout", cout8, ec);
            check("t6_ovf", ovf8, eo);
            tick();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
